// File: rtl/wave_capture_ctrl_pkg.sv
// Shared definitions for the waveform capture sequencer: default buffer
// geometry, counter widths and the capture state encoding.
package wave_capture_ctrl_pkg;

  localparam int DEPTH_DEF = 1280;
  localparam int AW_DEF    = 11;
  localparam int DW_DEF    = 10;
  localparam int CNT_W     = 11;
  localparam int TICK_W    = 16;

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_HOLD  = 2'd3
  } cap_state_t;

endpackage

// File: rtl/wave_trig_detect.sv
// Edge trigger detector: remembers the last accepted sample and flags a
// level crossing (rising or falling) on the current accepted sample.
module wave_trig_detect
  import wave_capture_ctrl_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic          clk_sample,
  input  logic          rst_n,
  input  logic          sample_en,
  input  logic          track,
  input  logic          clear,
  input  logic [DW-1:0] sample,
  input  logic [DW-1:0] trig_level,
  input  logic          trig_falling,
  output logic          trig_hit
);

  logic [DW-1:0] prev;
  logic          prev_valid;
  logic          rise_hit;
  logic          fall_hit;

  assign rise_hit = (prev < trig_level) && (sample >= trig_level);
  assign fall_hit = (prev >= trig_level) && (sample < trig_level);
  assign trig_hit = sample_en && track && prev_valid && (trig_falling ? fall_hit : rise_hit);

  // Track the previous accepted sample; a fresh capture starts with no history.
  always_ff @(posedge clk_sample) begin
    if (!rst_n) begin
      prev_valid <= 1'b0;
    end else if (clear) begin
      prev_valid <= 1'b0;
    end else if (sample_en && track) begin
      prev       <= sample;
      prev_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/wave_capture_ctrl.sv
// Capture sequencer for the display sample buffer: fills a pre-trigger
// window, waits for an edge (or timeout), records the post-trigger part and
// then holds the trace until re-armed.
module wave_capture_ctrl
  import wave_capture_ctrl_pkg::*;
#(
  parameter int DEPTH      = DEPTH_DEF,
  parameter int AW         = AW_DEF,
  parameter int DW         = DW_DEF,
  parameter int PRE_TRIG   = 640,
  parameter int AUTO_TICKS = 4000,
  parameter int HOLD_TICKS = 2000
) (
  input  logic          clk_sample,
  input  logic          rst_n,
  input  logic          sample_en,
  input  logic [DW-1:0] wave_sample,
  input  logic [DW-1:0] trig_level,
  input  logic          trig_falling,
  input  logic          single_mode,
  input  logic          arm,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  output logic [AW-1:0] display_base,
  output logic          capture_valid,
  output logic          auto_trig,
  output logic          busy
);

  // Number of samples written after the trigger sample itself.
  localparam int POST_N = DEPTH - PRE_TRIG - 1;

  localparam logic [CNT_W-1:0]  FILL_LAST = CNT_W'(PRE_TRIG - 1);
  localparam logic [CNT_W-1:0]  POST_LAST = CNT_W'(POST_N - 1);
  localparam logic [TICK_W-1:0] AUTO_LAST = TICK_W'(AUTO_TICKS - 1);
  localparam logic [TICK_W-1:0] HOLD_LAST = TICK_W'(HOLD_TICKS - 1);
  localparam logic [TICK_W-1:0] TICK_MAX  = '1;

  cap_state_t        state;
  logic [AW-1:0]     wr_ptr;
  logic [CNT_W-1:0]  fill_cnt;
  logic [CNT_W-1:0]  post_cnt;
  logic [TICK_W-1:0] auto_cnt;
  logic [TICK_W-1:0] hold_cnt;
  logic              accept;
  logic              hold_exit;
  logic              trig_hit;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign accept    = sample_en && (state != ST_HOLD);
  assign hold_exit = (state == ST_HOLD) &&
                     (arm || (!single_mode && sample_en && (hold_cnt >= HOLD_LAST)));

  wave_trig_detect #(.DW(DW)) u_trig (
    .clk_sample   (clk_sample),
    .rst_n        (rst_n),
    .sample_en    (sample_en),
    .track        (state != ST_HOLD),
    .clear        (hold_exit),
    .sample       (wave_sample),
    .trig_level   (trig_level),
    .trig_falling (trig_falling),
    .trig_hit     (trig_hit)
  );

  // Capture FSM, write port registers and capture status in one process.
  always_ff @(posedge clk_sample) begin
    if (!rst_n) begin
      state         <= ST_FILL;
      wr_ptr        <= '0;
      fill_cnt      <= '0;
      post_cnt      <= '0;
      auto_cnt      <= '0;
      hold_cnt      <= '0;
      wr_en         <= 1'b0;
      wr_addr       <= '0;
      wr_data       <= '0;
      display_base  <= '0;
      capture_valid <= 1'b0;
      auto_trig     <= 1'b0;
      busy          <= 1'b1;
    end else begin
      wr_en <= accept;
      if (accept) begin
        wr_addr <= wr_ptr;
        wr_data <= wave_sample;
        wr_ptr  <= ptr_inc(wr_ptr);
      end
      case (state)
        ST_FILL: begin
          if (sample_en) begin
            if (fill_cnt == FILL_LAST) begin
              state    <= ST_ARMED;
              fill_cnt <= '0;
              auto_cnt <= '0;
            end else begin
              fill_cnt <= fill_cnt + CNT_W'(1);
            end
          end
        end
        ST_ARMED: begin
          if (sample_en) begin
            if (trig_hit || (auto_cnt == AUTO_LAST)) begin
              auto_trig <= !trig_hit;
              auto_cnt  <= '0;
              if (POST_N == 0) begin
                state         <= ST_HOLD;
                busy          <= 1'b0;
                display_base  <= ptr_inc(wr_ptr);
                capture_valid <= 1'b1;
                hold_cnt      <= '0;
              end else begin
                state    <= ST_POST;
                post_cnt <= '0;
              end
            end else begin
              auto_cnt <= auto_cnt + TICK_W'(1);
            end
          end
        end
        ST_POST: begin
          if (sample_en) begin
            if (post_cnt == POST_LAST) begin
              state         <= ST_HOLD;
              busy          <= 1'b0;
              display_base  <= ptr_inc(wr_ptr);
              capture_valid <= 1'b1;
              post_cnt      <= '0;
              hold_cnt      <= '0;
            end else begin
              post_cnt <= post_cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          if (hold_exit) begin
            state    <= ST_FILL;
            busy     <= 1'b1;
            fill_cnt <= '0;
            hold_cnt <= '0;
          end else if (sample_en && (hold_cnt != TICK_MAX)) begin
            hold_cnt <= hold_cnt + TICK_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wave_capture_ctrl.sv
// Randomized bench for wave_capture_ctrl with a sample-level reference model
// of the capture rules and a mirror of the sample buffer.
module tb_wave_capture_ctrl;

  localparam int DEPTH      = 96;
  localparam int AW         = 11;
  localparam int DW         = 10;
  localparam int PRE_TRIG   = 30;
  localparam int AUTO_TICKS = 150;
  localparam int HOLD_TICKS = 60;

  localparam int PH_FILL  = 0;
  localparam int PH_ARMED = 1;
  localparam int PH_POST  = 2;
  localparam int PH_HOLD  = 3;

  logic          clk_sample = 1'b0;
  logic          rst_n;
  logic          sample_en;
  logic [DW-1:0] wave_sample;
  logic [DW-1:0] trig_level;
  logic          trig_falling;
  logic          single_mode;
  logic          arm;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [AW-1:0] display_base;
  logic          capture_valid;
  logic          auto_trig;
  logic          busy;

  wave_capture_ctrl #(
    .DEPTH(DEPTH), .AW(AW), .DW(DW), .PRE_TRIG(PRE_TRIG),
    .AUTO_TICKS(AUTO_TICKS), .HOLD_TICKS(HOLD_TICKS)
  ) dut (
    .clk_sample    (clk_sample),
    .rst_n         (rst_n),
    .sample_en     (sample_en),
    .wave_sample   (wave_sample),
    .trig_level    (trig_level),
    .trig_falling  (trig_falling),
    .single_mode   (single_mode),
    .arm           (arm),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .display_base  (display_base),
    .capture_valid (capture_valid),
    .auto_trig     (auto_trig),
    .busy          (busy)
  );

  always #5 clk_sample = ~clk_sample;

  int checks = 0;
  int errors = 0;

  // Reference model state, expressed in samples written per capture phase.
  int m_phase, m_cnt, m_hold, m_ptr, m_prev, m_pv;
  int m_wr_en, m_wr_addr, m_wr_data, m_base, m_cv, m_at, m_busy;
  int m_trig_addr, m_trig_val, m_done;
  int mem [DEPTH];

  task automatic check_val(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input logic rn, input logic se, input int s, input logic a);
    int hit;
    int lvl;
    if (!rn) begin
      m_phase = PH_FILL; m_cnt = 0; m_hold = 0; m_ptr = 0; m_pv = 0;
      m_wr_en = 0; m_wr_addr = 0; m_wr_data = 0;
      m_base = 0; m_cv = 0; m_at = 0; m_busy = 1; m_done = 0;
      return;
    end
    m_wr_en = 0;
    if (m_phase == PH_HOLD) begin
      if (se) m_hold++;
      if (a || (!single_mode && se && m_hold >= HOLD_TICKS)) begin
        m_phase = PH_FILL; m_cnt = 0; m_pv = 0; m_busy = 1;
      end
      return;
    end
    if (!se) return;
    m_wr_en = 1; m_wr_addr = m_ptr; m_wr_data = s;
    m_ptr = (m_ptr + 1) % DEPTH;
    lvl = int'(trig_level);
    if (trig_falling) hit = (m_pv != 0 && m_prev >= lvl && s < lvl) ? 1 : 0;
    else              hit = (m_pv != 0 && m_prev < lvl && s >= lvl) ? 1 : 0;
    m_prev = s; m_pv = 1; m_cnt++;
    case (m_phase)
      PH_FILL: if (m_cnt == PRE_TRIG) begin m_phase = PH_ARMED; m_cnt = 0; end
      PH_ARMED: if (hit != 0 || m_cnt == AUTO_TICKS) begin
        m_at = (hit != 0) ? 0 : 1;
        m_trig_addr = m_wr_addr; m_trig_val = s;
        m_phase = PH_POST; m_cnt = 0;
      end
      default: if (m_cnt == DEPTH - PRE_TRIG - 1) begin
        m_phase = PH_HOLD; m_base = m_ptr; m_cv = 1; m_busy = 0;
        m_hold = 0; m_done = 1;
      end
    endcase
  endtask

  task automatic compare_all();
    check_val("wr_en", int'(wr_en), m_wr_en);
    check_val("wr_addr", int'(wr_addr), m_wr_addr);
    check_val("wr_data", int'(wr_data), m_wr_data);
    check_val("display_base", int'(display_base), m_base);
    check_val("capture_valid", int'(capture_valid), m_cv);
    check_val("auto_trig", int'(auto_trig), m_at);
    check_val("busy", int'(busy), m_busy);
    if (m_done != 0) begin
      m_done = 0;
      check_val("base_align", int'(display_base), (m_trig_addr - PRE_TRIG + DEPTH) % DEPTH);
      if (int'(display_base) < DEPTH)
        check_val("trig_in_buffer", mem[(int'(display_base) + PRE_TRIG) % DEPTH], m_trig_val);
    end
  endtask

  task automatic step(input logic rn, input logic se, input int s, input logic a);
    rst_n = rn; sample_en = se; wave_sample = DW'(s); arm = a;
    model_step(rn, se, s, a);
    @(negedge clk_sample);
    if (wr_en && int'(wr_addr) < DEPTH) mem[int'(wr_addr)] = int'(wr_data);
    compare_all();
  endtask

  initial begin
    int wave_kind, v, dir, stp, arm_div, se_prev, post_rst;
    logic se, a, rn;
    rst_n = 1'b0; sample_en = 1'b0; wave_sample = '0; arm = 1'b0;
    trig_level = 10'd512; trig_falling = 1'b0; single_mode = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem[i] = -1;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 0, 1'b0);
    se_prev = 0;
    for (int scen = 0; scen < 10; scen++) begin
      v = 0; dir = 1; stp = 1; arm_div = 400; post_rst = 0;
      trig_falling = 1'b0; single_mode = 1'b0;
      case (scen)
        0: begin wave_kind = 0; trig_level = 10'd512; stp = 1; v = 384; end
        1: begin wave_kind = 1; v = 100; trig_level = 10'd512; end
        2: begin wave_kind = 1; v = 300; trig_level = 10'd0; end
        3: begin wave_kind = 3; single_mode = 1'b1; arm_div = 1500; trig_level = 10'd400; end
        4: begin wave_kind = 2; trig_falling = 1'b1; stp = 37; trig_level = 10'd600; end
        5: begin wave_kind = 0; stp = 29; trig_level = 10'd700; post_rst = 1; end
        default: begin
          wave_kind = int'($urandom_range(0, 3));
          v = int'($urandom_range(0, 1023));
          stp = int'($urandom_range(1, 60));
          trig_level = DW'($urandom_range(0, 1023));
          trig_falling = 1'($urandom_range(0, 1));
          single_mode = 1'($urandom_range(0, 1));
          arm_div = 200;
        end
      endcase
      for (int c = 0; c < 2500; c++) begin
        se = (se_prev == 0 && $urandom_range(0, 2) != 0) ? 1'b1 : 1'b0;
        a = ($urandom_range(0, arm_div - 1) == 0) ? 1'b1 : 1'b0;
        rn = 1'b1;
        if (post_rst != 0 && m_phase == PH_POST && m_cnt > 10) begin
          rn = 1'b0; post_rst = 0;
        end else if (scen >= 6 && $urandom_range(0, 1999) == 0) begin
          rn = 1'b0;
        end
        if (scen >= 6 && $urandom_range(0, 499) == 0) begin
          trig_level = DW'($urandom_range(0, 1023));
          trig_falling = 1'($urandom_range(0, 1));
        end
        if (se) begin
          case (wave_kind)
            0: v = (v + stp) % 1024;
            1: v = v;
            2: begin
              v = v + dir * stp;
              if (v > 1023) begin v = 1023; dir = -1; end
              if (v < 0) begin v = 0; dir = 1; end
            end
            default: v = int'($urandom_range(0, 1023));
          endcase
        end
        step(rn, se, v, a);
        se_prev = se ? 1 : 0;
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
